// File: rtl/tg2_csr_pkg.sv
// ============================================================================
// Package : tg2_csr_pkg
// Purpose : Shared types and constants for the mem TG2 CSR endpoint. It holds
//           the channel count, the per-channel status field layout, the
//           control image, and the per-channel sequencer state encoding.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package tg2_csr_pkg;

  // Number of memory channels served by the TG2 CSR block (1..8).
  localparam int M_CHANNEL = 4;

  // Width of one channel's status field in MEM_TG_STAT.
  localparam int TG_STAT_W = 4;

  // One channel's status field in MEM_TG_STAT, MSB first.
  typedef struct packed {
    logic pass;
    logic fail;
    logic timeout;
    logic active;
  } t_tg_stat;

  // Full MEM_TG_STAT image; channel n occupies [4n+3:4n].
  typedef t_tg_stat [M_CHANNEL-1:0] t_csr_tg_stat;

  // MEM_TG_CTRL image; bit n is tg_init_n for channel n.
  typedef struct packed {
    logic [M_CHANNEL-1:0] tg_init_n;
  } t_tg_ctrl;

  // Per-channel sequencer state.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } t_tg_seq_state;

endpackage

`default_nettype wire

// File: rtl/mem_tg2_ch_fsm.sv
// ============================================================================
// Module  : mem_tg2_ch_fsm
// Purpose : One channel of the TG2 sequencer: host control edge detect, the
//           IDLE/RUN/DONE state machine, optional local watchdog, and the
//           sticky pass/fail/timeout result capture.
// Ports   : clk, rst          - clock, asynchronous active-high reset
//           ctrl_i            - tg_init_n bit for this channel
//           ip_pass_i/_fail_i/_timeout_i - engine completion reports
//           tg_start_o        - one-cycle start pulse to the engine
//           stat_o            - {pass, fail, timeout, active}
//           enter_o           - this channel enters RUN at the next edge
//           run_d_o           - this channel is in RUN after the next edge
// Config  : MEM_TG2_SEQ_WATCHDOG_EN enables the local watchdog counter.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_tg2_ch_fsm
  import tg2_csr_pkg::*;
#(
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd100_000_000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ctrl_i,
  input  logic                 ip_pass_i,
  input  logic                 ip_fail_i,
  input  logic                 ip_timeout_i,
  output logic                 tg_start_o,
  output logic [TG_STAT_W-1:0] stat_o,
  output logic                 enter_o,
  output logic                 run_d_o
);

  t_tg_seq_state state_q;

  logic ctrl_q;
  logic primed_q;     // low only in the first cycle after reset release
  logic start_q;      // registered 0->1 edge of ctrl_i
  logic ip_pass_q;
  logic ip_fail_q;
  logic ip_timeout_q;
  logic tg_start_q;
  logic active_q;
  logic pass_q;
  logic fail_q;
  logic timeout_q;

  logic in_run;
  logic wd_hit;
  logic enter_d;
  logic fail_d;
  logic timeout_d;
  logic pass_d;
  logic exit_d;
  logic run_d;

`ifdef MEM_TG2_SEQ_WATCHDOG_EN
  logic [31:0] wd_q;
  assign wd_hit = (wd_q == (TIMEOUT_CYCLES - 32'd1));
`else
  assign wd_hit = 1'b0;
`endif

  // Result decision from the engine reports sampled on the previous edge.
  // Priority: fail > timeout (engine or local) > pass, so exactly one
  // result bit is set on exit.
  always_comb begin
    in_run    = (state_q == RUN);
    enter_d   = start_q & ~in_run;
    fail_d    = in_run & ip_fail_q;
    timeout_d = in_run & ~ip_fail_q & (ip_timeout_q | wd_hit);
    pass_d    = in_run & ~ip_fail_q & ~ip_timeout_q & ~wd_hit & ip_pass_q;
    exit_d    = fail_d | timeout_d | pass_d;
    run_d     = enter_d | (in_run & ~exit_d);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      ctrl_q       <= 1'b0;
      primed_q     <= 1'b0;
      start_q      <= 1'b0;
      ip_pass_q    <= 1'b0;
      ip_fail_q    <= 1'b0;
      ip_timeout_q <= 1'b0;
      tg_start_q   <= 1'b0;
      active_q     <= 1'b0;
      pass_q       <= 1'b0;
      fail_q       <= 1'b0;
      timeout_q    <= 1'b0;
`ifdef MEM_TG2_SEQ_WATCHDOG_EN
      wd_q         <= 32'd0;
`endif
    end else begin
      // The first post-reset cycle only captures the control level, so a
      // bit held high through reset does not look like a new edge.
      primed_q <= 1'b1;
      ctrl_q   <= ctrl_i;
      start_q  <= primed_q & ctrl_i & ~ctrl_q;

      // Engine reports are only meaningful while a run is in progress.
      ip_pass_q    <= ip_pass_i & in_run;
      ip_fail_q    <= ip_fail_i & in_run;
      ip_timeout_q <= ip_timeout_i & in_run;

      tg_start_q <= enter_d;

      case (state_q)
        IDLE, DONE: begin
          if (enter_d) begin
            state_q   <= RUN;
            active_q  <= 1'b1;
            pass_q    <= 1'b0;
            fail_q    <= 1'b0;
            timeout_q <= 1'b0;
`ifdef MEM_TG2_SEQ_WATCHDOG_EN
            wd_q      <= 32'd0;
`endif
          end
        end
        RUN: begin
          if (exit_d) begin
            state_q   <= DONE;
            active_q  <= 1'b0;
            pass_q    <= pass_d;
            fail_q    <= fail_d;
            timeout_q <= timeout_d;
          end
`ifdef MEM_TG2_SEQ_WATCHDOG_EN
          else begin
            wd_q <= wd_q + 32'd1;
          end
`endif
        end
        default: begin
          state_q  <= IDLE;
          active_q <= 1'b0;
        end
      endcase
    end
  end

  assign tg_start_o = tg_start_q;
  assign stat_o     = {pass_q, fail_q, timeout_q, active_q};
  assign enter_o    = enter_d;
  assign run_d_o    = run_d;

endmodule

`default_nettype wire

// File: rtl/mem_tg2_ch_sequencer.sv
// ============================================================================
// Module  : mem_tg2_ch_sequencer
// Purpose : Hardware endpoint of the mem TG2 control/status CSRs. Turns host
//           tg_init_n edges into engine start pulses, collects per-channel
//           results into MEM_TG_STAT and keeps the MEM_TG_CLOCKS run time.
// Ports   : clk, rst         - clock, asynchronous active-high reset
//           csr_tg_ctrl      - tg_init_n bits, bit n = channel n
//           csr_tg_stat      - ch n at [4n+3:4n] = {pass, fail, timeout, active}
//           csr_tg_clocks    - cycles with at least one channel running
//           tg_start         - one-cycle start pulse per engine
//           tg_ip_pass/_fail/_timeout - per-engine completion reports
// Config  : MEM_TG2_SEQ_WATCHDOG_EN enables the per-channel local watchdog.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_tg2_ch_sequencer
  import tg2_csr_pkg::*;
#(
  parameter int          M_CHANNEL      = tg2_csr_pkg::M_CHANNEL,
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd100_000_000
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [M_CHANNEL-1:0]           csr_tg_ctrl,
  output logic [TG_STAT_W*M_CHANNEL-1:0] csr_tg_stat,
  output logic [63:0]                    csr_tg_clocks,
  output logic [M_CHANNEL-1:0]           tg_start,
  input  logic [M_CHANNEL-1:0]           tg_ip_pass,
  input  logic [M_CHANNEL-1:0]           tg_ip_fail,
  input  logic [M_CHANNEL-1:0]           tg_ip_timeout
);

  logic [M_CHANNEL-1:0] enter_w;
  logic [M_CHANNEL-1:0] run_d_w;
  logic [M_CHANNEL-1:0] active_w;
  logic [63:0]          clocks_q;
  logic [63:0]          clocks_d;

  for (genvar n = 0; n < M_CHANNEL; n++) begin : g_ch
    logic [TG_STAT_W-1:0] stat_w;

    mem_tg2_ch_fsm #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_ch_fsm (
      .clk         (clk),
      .rst         (rst),
      .ctrl_i      (csr_tg_ctrl[n]),
      .ip_pass_i   (tg_ip_pass[n]),
      .ip_fail_i   (tg_ip_fail[n]),
      .ip_timeout_i(tg_ip_timeout[n]),
      .tg_start_o  (tg_start[n]),
      .stat_o      (stat_w),
      .enter_o     (enter_w[n]),
      .run_d_o     (run_d_w[n])
    );

    assign csr_tg_stat[TG_STAT_W*n +: TG_STAT_W] = stat_w;
    assign active_w[n]                           = stat_w[0];
  end

  // The count equals the number of cycles with any active bit set since the
  // first channel of a busy period started. A fresh busy period loads 1 to
  // count its own entry cycle; a staggered start joins the running period.
  always_comb begin
    clocks_d = clocks_q;
    if ((|enter_w) && !(|active_w)) begin
      clocks_d = 64'd1;
    end else if ((|run_d_w) && (clocks_q != {64{1'b1}})) begin
      clocks_d = clocks_q + 64'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clocks_q <= 64'd0;
    end else begin
      clocks_q <= clocks_d;
    end
  end

  assign csr_tg_clocks = clocks_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_tg2_ch_sequencer.sv
// ============================================================================
// Module  : tb_mem_tg2_ch_sequencer
// Purpose : Self-checking bench for mem_tg2_ch_sequencer (2 channels, short
//           watchdog limit). Directed scenarios followed by random traffic,
//           all checked against a transaction-level reference model.
// Config  : honours MEM_TG2_SEQ_WATCHDOG_EN like the design.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_tg2_ch_sequencer;

  localparam int          NCH = 2;
  localparam logic [31:0] TO  = 32'd16;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [NCH-1:0]   ctrl = '0;
  logic [NCH-1:0]   ip_pass = '0;
  logic [NCH-1:0]   ip_fail = '0;
  logic [NCH-1:0]   ip_to = '0;
  logic [4*NCH-1:0] stat;
  logic [63:0]      clocks;
  logic [NCH-1:0]   tg_start;

  int checks   = 0;
  int failures = 0;
  int pulses;

  always #5 clk = ~clk;

  mem_tg2_ch_sequencer #(
    .M_CHANNEL     (NCH),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .csr_tg_ctrl  (ctrl),
    .csr_tg_stat  (stat),
    .csr_tg_clocks(clocks),
    .tg_start     (tg_start),
    .tg_ip_pass   (ip_pass),
    .tg_ip_fail   (ip_fail),
    .tg_ip_timeout(ip_to)
  );

  // ---------------- reference model ----------------
  // Rules: a host 0->1 edge seen at one edge starts the run at the following
  // edge (unless already running); a report seen at one edge ends the run at
  // the following edge; run time = cycles with any channel active.
  bit             m_primed;
  bit [NCH-1:0]   m_prev_ctrl, m_pend_start, m_active, m_start;
  bit [2:0]       m_pend_res [NCH];   // {pass, fail, timeout} seen last edge
  bit [2:0]       m_res      [NCH];   // {pass, fail, timeout} sticky result
  int unsigned    m_age      [NCH];   // completed RUN cycles without exit
  logic [63:0]    m_clocks;

  function automatic bit [2:0] outcome(bit [2:0] r, int unsigned age);
    bit wd;
    wd = 1'b0;
`ifdef MEM_TG2_SEQ_WATCHDOG_EN
    wd = (age == TO - 1);
`endif
    if (r[1])        return 3'b010;
    if (r[0] || wd)  return 3'b001;
    if (r[2])        return 3'b100;
    return 3'b000;
  endfunction

  task automatic model_reset();
    m_primed = 0; m_prev_ctrl = '0; m_pend_start = '0;
    m_active = '0; m_start = '0; m_clocks = 64'd0;
    for (int n = 0; n < NCH; n++) begin
      m_pend_res[n] = 3'b000; m_res[n] = 3'b000; m_age[n] = 0;
    end
  endtask

  task automatic model_edge();
    bit         any_before, any_enter;
    bit [NCH-1:0] was_active, old_pend_start;
    bit [2:0]   r;
    if (rst) begin
      model_reset();
      return;
    end
    any_before     = |m_active;
    any_enter      = 0;
    was_active     = m_active;
    old_pend_start = m_pend_start;
    for (int n = 0; n < NCH; n++) begin
      m_start[n] = 0;
      if (old_pend_start[n] && !was_active[n]) begin
        m_active[n] = 1; m_res[n] = 3'b000; m_age[n] = 0;
        m_start[n] = 1; any_enter = 1;
      end else if (was_active[n]) begin
        r = outcome(m_pend_res[n], m_age[n]);
        if (r != 3'b000) begin
          m_active[n] = 0; m_res[n] = r;
        end else begin
          m_age[n]++;
        end
      end
      m_pend_res[n]   = was_active[n] ? {ip_pass[n], ip_fail[n], ip_to[n]} : 3'b000;
      m_pend_start[n] = m_primed && ctrl[n] && !m_prev_ctrl[n];
      m_prev_ctrl[n]  = ctrl[n];
    end
    m_primed = 1;
    if (any_enter && !any_before)                   m_clocks = 64'd1;
    else if ((|m_active) && (m_clocks != '1))       m_clocks = m_clocks + 64'd1;
  endtask

  function automatic logic [4*NCH-1:0] m_stat();
    logic [4*NCH-1:0] s;
    for (int n = 0; n < NCH; n++) s[4*n +: 4] = {m_res[n], m_active[n]};
    return s;
  endfunction

  // ---------------- checking ----------------
  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(int cnt = 1);
    for (int i = 0; i < cnt; i++) begin
      model_edge();
      @(posedge clk);
      #1;
      chk("tg_start", 64'(tg_start), 64'(m_start));
      chk("stat",     64'(stat),     64'(m_stat()));
      chk("clocks",   clocks,        m_clocks);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "bench time limit");
  end

  initial begin
    // ---- reset ----
    model_reset();
    #2;
    chk("reset_stat",   64'(stat),     64'd0);
    chk("reset_start",  64'(tg_start), 64'd0);
    chk("reset_clocks", clocks,        64'd0);
    tick(2);
    rst = 1'b0;
    tick(2);

    // ---- ch0 start, pass 50 cycles after start ----
    ctrl[0] = 1'b1;
    tick();
    chk("start_latency", 64'(tg_start), 64'd0);
    tick();
    chk("start_pulse", 64'(tg_start[0]), 64'd1);
    chk("start_stat",  64'(stat[3:0]),   64'b0001);
    tick(49);
    ip_pass[0] = 1'b1;
    tick();
    ip_pass[0] = 1'b0;
    tick();
`ifdef MEM_TG2_SEQ_WATCHDOG_EN
    chk("pass50_stat",   64'(stat[3:0]), 64'b0010);
    chk("pass50_clocks", clocks,         64'd16);
`else
    chk("pass50_stat",   64'(stat[3:0]), 64'b1000);
    chk("pass50_clocks", clocks,         64'd51);
`endif

    // ---- ch1 pass and fail together: fail wins ----
    ctrl[1] = 1'b1;
    tick(2);
    ip_pass[1] = 1'b1; ip_fail[1] = 1'b1;
    tick();
    ip_pass[1] = 1'b0; ip_fail[1] = 1'b0;
    tick();
    chk("passfail_stat", 64'(stat[7:4]), 64'b0100);

    // ---- no engine response: local watchdog ----
    ctrl[0] = 1'b0;
    tick();
    ctrl[0] = 1'b1;
    tick(2);
    tick(16);
`ifdef MEM_TG2_SEQ_WATCHDOG_EN
    chk("wd_stat",   64'(stat[3:0]), 64'b0010);
    chk("wd_clocks", clocks,         64'd16);
`else
    chk("wd_stat",   64'(stat[3:0]), 64'b0001);
`endif

    // ---- toggling ctrl during RUN gives a single start ----
    ip_fail[0] = 1'b1;
    tick();
    ip_fail[0] = 1'b0;
    tick(2);
    ctrl[0] = 1'b0;
    tick();
    pulses = 0;
    ctrl[0] = 1'b1; tick(); pulses += int'(tg_start[0]);
    tick();                 pulses += int'(tg_start[0]);
    ctrl[0] = 1'b0; tick(); pulses += int'(tg_start[0]);
    ctrl[0] = 1'b1; tick(); pulses += int'(tg_start[0]);
    ctrl[0] = 1'b0; tick(); pulses += int'(tg_start[0]);
    ctrl[0] = 1'b1; tick(); pulses += int'(tg_start[0]);
    tick();                 pulses += int'(tg_start[0]);
    chk("single_start", 64'(pulses), 64'd1);
    ip_pass[0] = 1'b1;
    tick();
    ip_pass[0] = 1'b0;
    tick();
    chk("toggle_done", 64'(stat[3:0]), 64'b1000);
    ctrl[0] = 1'b0;
    tick();
    ctrl[0] = 1'b1;
    tick(2);
    chk("restart_pulse",  64'(tg_start[0]), 64'd1);
    chk("restart_stat",   64'(stat[3:0]),   64'b0001);
    chk("restart_clocks", clocks,           64'd1);
    ip_fail[0] = 1'b1;
    tick();
    ip_fail[0] = 1'b0;
    tick();

    // ---- staggered starts: ch1 joins without clearing clocks ----
    ctrl = '0;
    tick();
    ctrl[0] = 1'b1;
    tick(2);
    for (int k = 1; k <= 41; k++) begin
      ctrl[1]    = (k >= 9);
      ip_pass[0] = (k == 20);
      ip_pass[1] = (k == 40);
      tick();
    end
    ip_pass = '0;
`ifdef MEM_TG2_SEQ_WATCHDOG_EN
    chk("stagger_clocks", clocks,    64'd26);
    chk("stagger_stat",   64'(stat), 64'b0010_0010);
`else
    chk("stagger_clocks", clocks,    64'd41);
    chk("stagger_stat",   64'(stat), 64'b1000_1000);
`endif

    // ---- reset in the middle of a run with ctrl held high ----
    ctrl = '0;
    tick();
    ctrl[0] = 1'b1;
    tick(5);
    rst = 1'b1;
    #1;
    chk("arst_stat",   64'(stat),     64'd0);
    chk("arst_start",  64'(tg_start), 64'd0);
    chk("arst_clocks", clocks,        64'd0);
    model_reset();
    tick(2);
    rst = 1'b0;
    pulses = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      pulses += int'(tg_start[0]);
    end
    chk("no_start_after_rst", 64'(pulses), 64'd0);
    ctrl[0] = 1'b0;
    tick();
    ctrl[0] = 1'b1;
    tick(2);
    chk("start_after_rst", 64'(tg_start[0]), 64'd1);

    // ---- random traffic against the model ----
    for (int c = 0; c < 500; c++) begin
      for (int n = 0; n < NCH; n++) begin
        if ($urandom_range(5) == 0) ctrl[n] = ~ctrl[n];
        ip_pass[n] = ($urandom_range(9) == 0);
        ip_fail[n] = ($urandom_range(14) == 0);
        ip_to[n]   = ($urandom_range(19) == 0);
      end
      tick();
    end
    ip_pass = '0; ip_fail = '0; ip_to = '0;
    tick(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mem_tg2_ch_sequencer.md
Name: mem_tg2_ch_sequencer

Overview:
Hardware-side endpoint of the mem TG2 control/status CSRs. It consumes the per-channel tg_init_n bits written by the host into MEM_TG_CTRL and produces the per-channel {pass, fail, timeout, active} fields read from MEM_TG_STAT, plus the MEM_TG_CLOCKS run-time count. It sits between the TG2 CSR block and the per-channel TG2 traffic engines: it issues start pulses to the engines and collects their completion results.

Parameters:
M_CHANNEL, tg2_csr_pkg::M_CHANNEL, number of memory channels (1..8)
TIMEOUT_CYCLES, 32'd100_000_000, local watchdog limit per run in clk cycles (>=2)

Ports:
clk  in  1  single clock for all logic
rst  in  1  asynchronous active-high reset
csr_tg_ctrl  in  M_CHANNEL  tg_init_n bits from MEM_TG_CTRL; bit n = channel n
csr_tg_stat  out  4*M_CHANNEL  t_csr_tg_stat image; ch n at [4n+3:4n] = {pass, fail, timeout, active}
csr_tg_clocks  out  64  MEM_TG_CLOCKS value
tg_start  out  M_CHANNEL  one-cycle start pulse to TG2 engine n
tg_ip_pass  in  M_CHANNEL  engine n reports pass (level or pulse)
tg_ip_fail  in  M_CHANNEL  engine n reports fail
tg_ip_timeout  in  M_CHANNEL  engine n reports internal timeout

Behaviour:
- Reset (async assert, sync release): all outputs 0; every channel FSM in IDLE; ctrl edge register cleared to 0.
- ctrl_q registered copy of csr_tg_ctrl; start_req[n] = csr_tg_ctrl[n] & ~ctrl_q[n] (0->1 edge). Host keeps bit high or clears it; only edges matter.
- Per-channel FSM: IDLE, RUN, DONE.
  - IDLE/DONE + start_req: next cycle -> RUN; tg_start[n]=1 for exactly that one cycle; active=1; pass/fail/timeout cleared the same cycle; watchdog counter cleared to 0.
  - RUN: watchdog increments every cycle. Exit to DONE (active=0) on first of:
    fail input -> fail=1; pass input -> pass=1; tg_ip_timeout -> timeout=1; watchdog == TIMEOUT_CYCLES-1 -> timeout=1.
    Priority same cycle: fail > timeout (ip or local) > pass; exactly one result bit set.
  - Result inputs ignored in IDLE/DONE; DONE results sticky until next start_req.
  - start_req during RUN ignored (no restart, no second tg_start).
- Latency: ctrl 0->1 sampled at edge T -> tg_start/active visible after edge T+1. Result input sampled at edge R -> active=0, result bit=1 after edge R+1.
- csr_tg_clocks: 64-bit; cleared to 0 in the cycle any channel enters RUN while no channel is currently in RUN; increments by 1 every cycle at least one channel is in RUN (including entry cycle, excluding cycle active drops); saturates at 64'hFFFF_FFFF_FFFF_FFFF; held when idle.
- Channels independent; simultaneous starts on several channels legal; staggered start on a second channel while another runs does not clear clocks.
- rst mid-RUN: immediate return to reset values; no tg_start pulse generated on release even if csr_tg_ctrl held high (ctrl_q captures level first cycle after release; edge needs 0 then 1). Resolved: ctrl_q reset to 0 would create an edge, so ctrl_q loads csr_tg_ctrl during first post-reset cycle without start.

Optional Feature:
MEM_TG2_SEQ_WATCHDOG_EN: defined -> local watchdog counter per channel as above. Undefined -> no watchdog logic; RUN exits only on engine inputs; TIMEOUT_CYCLES unused; timeout bit set only by tg_ip_timeout.

Decomposition:
- tg2_csr_pkg: reuse t_tg_stat, t_csr_tg_stat, t_tg_ctrl, M_CHANNEL; add typedef enum t_tg_seq_state {IDLE, RUN, DONE} and localparam TG_STAT_W = 4.
- Sub-module mem_tg2_ch_fsm: one channel's edge detect, FSM, watchdog, result capture; generated M_CHANNEL times. Top holds shared clocks counter and stat packing.

Test Plan:
- Reset then ctrl[0] 0->1 -> tg_start[0] one cycle after sampling, stat[3:0]=4'b0001; tg_ip_pass[0] pulse 50 cycles later -> stat[3:0]=4'b1000, clocks=51.
- tg_ip_pass and tg_ip_fail same cycle on ch1 -> stat[7:4]=4'b0100 only.
- Watchdog enabled, TIMEOUT_CYCLES=16, no engine response -> after 16 RUN cycles stat=4'b0010, clocks=16; macro undefined -> stays 4'b0001.
- ctrl[0] toggled 0->1->0->1 during RUN -> single tg_start pulse; after DONE next 0->1 clears result, new pulse, clocks restart at 0.
- Ch0 starts, ch1 starts 10 cycles later, ch0 passes at 20, ch1 at 40 -> clocks=41 (not cleared by ch1 start).
- rst asserted mid-RUN with ctrl held 1 -> all outputs 0 asynchronously; after release no tg_start until ctrl goes 0 then 1.
